// File: rtl/keypad_events.sv
// keypad_events: debounces the 16-key CHIP-8 matrix keypad and turns debounced
// edges into one-cycle press/release pulses. It also answers the CPU's
// EX9E/EXA1 key query combinationally and runs the FX0A "wait for key"
// handshake, which reports a key only after it has been pressed and released.
//
// FX0A handshake: wait_valid is held high, with wait_key stable, from the
// cycle DONE is entered until the first rising edge of clk that samples
// wait_ack high. That sampled edge completes the transfer. wait_ack is
// ignored while wait_valid is low. A wait_start sampled in that same cycle
// chains directly into a new wait. Otherwise, wait_start is only honoured in
// IDLE.
module keypad_events #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] raw_keys,
  output logic [15:0] keys,
  output logic [15:0] press_pulse,
  output logic [15:0] release_pulse,
  input  logic [3:0]  query_key,
  output logic        query_pressed,
  input  logic        wait_start,
  output logic        wait_busy,
  output logic        wait_valid,
  output logic [3:0]  wait_key,
  input  logic        wait_ack
);

  // Terminal count. A key flips on the DEBOUNCE_CYCLES-th consecutive
  // mismatching sample.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } wait_state_t;

  // FSM state is kept as a named enum signal so that checkers can bind to it
  // directly.
  wait_state_t      wait_state;
  wait_state_t      wait_state_next;
  logic [3:0]       wait_key_next;
  logic [3:0]       lowest_press;
  logic [15:0]      key_flip;
  logic [CNT_W-1:0] cnt [16];

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------

  // A key flips when it still disagrees with the raw input on the last
  // counted sample.
  always_comb begin
    key_flip = '0;
    for (int i = 0; i < 16; i++) begin
      key_flip[i] = (raw_keys[i] != keys[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Per-key mismatch counters. A single matching sample clears the count,
  // so short glitches never reach keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (raw_keys[i] == keys[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state and its edge pulses. The pulses are registered
  // alongside keys, so each pulse coincides with the cycle in which keys
  // takes its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys          <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      keys          <= keys ^ key_flip;
      press_pulse   <= key_flip & raw_keys;
      release_pulse <= key_flip & ~raw_keys;
    end
  end

  // ---------------------------------------------------------------------------
  // Key query (EX9E / EXA1)
  // ---------------------------------------------------------------------------

  // Pure mux of the registered key state; adds no latency.
  always_comb begin
    query_pressed = keys[query_key];
  end

  // ---------------------------------------------------------------------------
  // FX0A wait FSM
  // ---------------------------------------------------------------------------

  // Priority encoder. When several keys are pressed together, the lowest
  // index wins.
  always_comb begin
    lowest_press = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (press_pulse[i]) begin
        lowest_press = 4'(i);
      end
    end
  end

  // State and captured key registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_state <= IDLE;
      wait_key   <= 4'd0;
    end else begin
      wait_state <= wait_state_next;
      wait_key   <= wait_key_next;
    end
  end

  // Next-state logic. Keys already held at wait_start are ignored, because
  // only new press_pulse events are considered.
  always_comb begin
    wait_state_next = wait_state;
    wait_key_next   = wait_key;
    case (wait_state)
      IDLE: begin
        if (wait_start) begin
          wait_state_next = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (press_pulse != 16'd0) begin
          wait_key_next   = lowest_press;
          wait_state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (release_pulse[wait_key]) begin
          wait_state_next = DONE;
        end
      end
      DONE: begin
        if (wait_ack) begin
          wait_state_next = wait_start ? WAIT_PRESS : IDLE;
        end
      end
      default: begin
        wait_state_next = IDLE;
      end
    endcase
  end

  // Status outputs are decoded straight from the state register, so they
  // are mutually exclusive by construction.
  always_comb begin
    wait_busy  = (wait_state == WAIT_PRESS) || (wait_state == WAIT_RELEASE);
    wait_valid = (wait_state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------

  a_pulse_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) (press_pulse & release_pulse) == 16'd0
  );

  a_status_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(wait_busy && wait_valid)
  );

endmodule

// File: tb/tb_keypad_events.sv
// Directed testbench for keypad_events (DEBOUNCE_CYCLES = 8). Each scenario
// task drives its own stimulus and checks results inline against
// hand-computed values.
module tb_keypad_events;

  logic        clk;
  logic        rst_n;
  logic [15:0] raw_keys;
  logic [15:0] keys;
  logic [15:0] press_pulse;
  logic [15:0] release_pulse;
  logic [3:0]  query_key;
  logic        query_pressed;
  logic        wait_start;
  logic        wait_busy;
  logic        wait_valid;
  logic [3:0]  wait_key;
  logic        wait_ack;

  int vectors;
  int miscompares;

  keypad_events #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_keys     (raw_keys),
    .keys         (keys),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .query_key    (query_key),
    .query_pressed(query_pressed),
    .wait_start   (wait_start),
    .wait_busy    (wait_busy),
    .wait_valid   (wait_valid),
    .wait_key     (wait_key),
    .wait_ack     (wait_ack)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Time limit so that a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge. Inputs are driven and outputs sampled 1 ns after the
  // active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    raw_keys   = 16'h0000;
    query_key  = 4'h0;
    wait_start = 1'b0;
    wait_ack   = 1'b0;
    repeat (3) step();
    vectors++;
    if (keys !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_keys got=%h exp=%h", keys, 16'h0000);
    end
    vectors++;
    if ((press_pulse | release_pulse) !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pulses got=%h/%h exp=0/0", press_pulse, release_pulse);
    end
    vectors++;
    if ({wait_busy, wait_valid, wait_key} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_wait got busy=%b valid=%b key=%h exp=0/0/0",
               wait_busy, wait_valid, wait_key);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_debounce();
    raw_keys = 16'h0020;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) begin
        vectors++;
        if (keys !== 16'h0000 || press_pulse !== 16'h0000) begin
          miscompares++;
          $display("FAIL deb_hold edge=%0d got keys=%h press=%h exp=0/0",
                   i, keys, press_pulse);
        end
      end else begin
        vectors++;
        if (keys !== 16'h0020 || press_pulse !== 16'h0020) begin
          miscompares++;
          $display("FAIL deb_rise got keys=%h press=%h exp=0020/0020",
                   keys, press_pulse);
        end
      end
    end
    step();
    vectors++;
    if (press_pulse !== 16'h0000 || keys !== 16'h0020) begin
      miscompares++;
      $display("FAIL deb_one_cycle got press=%h keys=%h exp=0000/0020",
               press_pulse, keys);
    end
    raw_keys = 16'h0000;
    repeat (7) step();
    vectors++;
    if (keys !== 16'h0020 || release_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL deb_fall_early got keys=%h rel=%h exp=0020/0000",
               keys, release_pulse);
    end
    step();
    vectors++;
    if (keys !== 16'h0000 || release_pulse !== 16'h0020 || press_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL deb_fall got keys=%h rel=%h press=%h exp=0000/0020/0000",
               keys, release_pulse, press_pulse);
    end
    step();
  endtask

  task automatic test_glitch();
    // 7 high, 1 low, 7 high, then low for good.
    for (int i = 0; i < 15; i++) begin
      raw_keys = (i == 7) ? 16'h0000 : 16'h0008;
      step();
      vectors++;
      if (keys[3] !== 1'b0 || press_pulse !== 16'h0000) begin
        miscompares++;
        $display("FAIL glitch cycle=%0d got keys=%h press=%h exp=0000/0000",
                 i, keys, press_pulse);
      end
    end
    raw_keys = 16'h0000;
    repeat (3) step();
    vectors++;
    if (keys !== 16'h0000) begin
      miscompares++;
      $display("FAIL glitch_after got keys=%h exp=0000", keys);
    end
  endtask

  task automatic test_query();
    raw_keys = 16'h8001;
    repeat (8) step();
    vectors++;
    if (keys !== 16'h8001) begin
      miscompares++;
      $display("FAIL query_keys got=%h exp=8001", keys);
    end
    query_key = 4'hF;
    #1;
    vectors++;
    if (query_pressed !== 1'b1) begin
      miscompares++;
      $display("FAIL query_F got=%b exp=1", query_pressed);
    end
    query_key = 4'h1;
    #1;
    vectors++;
    if (query_pressed !== 1'b0) begin
      miscompares++;
      $display("FAIL query_1 got=%b exp=0", query_pressed);
    end
    query_key = 4'h0;
    #1;
    vectors++;
    if (query_pressed !== 1'b1) begin
      miscompares++;
      $display("FAIL query_0 got=%b exp=1", query_pressed);
    end
    raw_keys = 16'h0000;
    repeat (9) step();
  endtask

  task automatic test_wait_basic();
    // Key A is held before the wait starts.
    raw_keys = 16'h0400;
    repeat (9) step();
    wait_start = 1'b1;
    step();
    wait_start = 1'b0;
    vectors++;
    if (wait_busy !== 1'b1 || wait_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fx_start got busy=%b valid=%b exp=1/0", wait_busy, wait_valid);
    end
    // Keys 5 and C are pressed in the same debounce window.
    raw_keys = 16'h1420;
    repeat (8) step();
    vectors++;
    if (press_pulse !== 16'h1020) begin
      miscompares++;
      $display("FAIL fx_press_pulse got=%h exp=1020", press_pulse);
    end
    step();
    vectors++;
    if (wait_key !== 4'h5 || wait_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fx_capture got key=%h busy=%b exp=5/1", wait_key, wait_busy);
    end
    // wait_ack outside DONE has no effect.
    wait_ack = 1'b1;
    step();
    wait_ack = 1'b0;
    vectors++;
    if (wait_busy !== 1'b1 || wait_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fx_stray_ack got busy=%b valid=%b exp=1/0", wait_busy, wait_valid);
    end
    // Releasing C does not complete the wait.
    raw_keys = 16'h0420;
    repeat (10) step();
    vectors++;
    if (wait_busy !== 1'b1 || wait_valid !== 1'b0 || wait_key !== 4'h5) begin
      miscompares++;
      $display("FAIL fx_other_release got busy=%b valid=%b key=%h exp=1/0/5",
               wait_busy, wait_valid, wait_key);
    end
    // Releasing 5 completes the wait one edge after its release pulse.
    raw_keys = 16'h0400;
    repeat (8) step();
    vectors++;
    if (release_pulse !== 16'h0020 || wait_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fx_release_pulse got rel=%h valid=%b exp=0020/0",
               release_pulse, wait_valid);
    end
    step();
    vectors++;
    if (wait_valid !== 1'b1 || wait_busy !== 1'b0 || wait_key !== 4'h5) begin
      miscompares++;
      $display("FAIL fx_done got valid=%b busy=%b key=%h exp=1/0/5",
               wait_valid, wait_busy, wait_key);
    end
    repeat (3) step();
    vectors++;
    if (wait_valid !== 1'b1 || wait_key !== 4'h5) begin
      miscompares++;
      $display("FAIL fx_hold got valid=%b key=%h exp=1/5", wait_valid, wait_key);
    end
    wait_ack = 1'b1;
    step();
    wait_ack = 1'b0;
    vectors++;
    if (wait_valid !== 1'b0 || wait_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fx_ack got valid=%b busy=%b exp=0/0", wait_valid, wait_busy);
    end
    raw_keys = 16'h0000;
    repeat (9) step();
  endtask

  task automatic test_back_to_back();
    wait_start = 1'b1;
    step();
    wait_start = 1'b0;
    raw_keys = 16'h0008;
    repeat (9) step();
    raw_keys = 16'h0000;
    repeat (9) step();
    vectors++;
    if (wait_valid !== 1'b1 || wait_key !== 4'h3) begin
      miscompares++;
      $display("FAIL b2b_first got valid=%b key=%h exp=1/3", wait_valid, wait_key);
    end
    wait_ack   = 1'b1;
    wait_start = 1'b1;
    step();
    wait_ack   = 1'b0;
    wait_start = 1'b0;
    vectors++;
    if (wait_busy !== 1'b1 || wait_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_chain got busy=%b valid=%b exp=1/0", wait_busy, wait_valid);
    end
    raw_keys = 16'h0001;
    repeat (9) step();
    vectors++;
    if (wait_key !== 4'h0 || wait_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_capture got key=%h busy=%b exp=0/1", wait_key, wait_busy);
    end
    raw_keys = 16'h0000;
    repeat (9) step();
    vectors++;
    if (wait_valid !== 1'b1 || wait_key !== 4'h0) begin
      miscompares++;
      $display("FAIL b2b_done got valid=%b key=%h exp=1/0", wait_valid, wait_key);
    end
    wait_ack = 1'b1;
    step();
    wait_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    wait_start = 1'b1;
    step();
    wait_start = 1'b0;
    raw_keys = 16'h0080;
    repeat (9) step();
    vectors++;
    if (wait_key !== 4'h7 || wait_busy !== 1'b1 || keys !== 16'h0080) begin
      miscompares++;
      $display("FAIL mid_setup got key=%h busy=%b keys=%h exp=7/1/0080",
               wait_key, wait_busy, keys);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (keys !== 16'h0000 || wait_busy !== 1'b0 || wait_valid !== 1'b0 ||
        wait_key !== 4'h0 || press_pulse !== 16'h0000 || release_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_async got keys=%h busy=%b valid=%b key=%h exp=0000/0/0/0",
               keys, wait_busy, wait_valid, wait_key);
    end
    step();
    rst_n = 1'b1;
    // Key 7 is still held, so it debounces back in while the FSM sits in IDLE.
    repeat (8) step();
    vectors++;
    if (keys !== 16'h0080 || press_pulse !== 16'h0080 || wait_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_repress got keys=%h press=%h busy=%b exp=0080/0080/0",
               keys, press_pulse, wait_busy);
    end
    raw_keys = 16'h0000;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 8) begin
        vectors++;
        if (release_pulse !== 16'h0080) begin
          miscompares++;
          $display("FAIL mid_release_pulse got=%h exp=0080", release_pulse);
        end
      end
      vectors++;
      if (wait_valid !== 1'b0 || wait_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_report cycle=%0d got valid=%b busy=%b exp=0/0",
                 i, wait_valid, wait_busy);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_debounce();
    test_glitch();
    test_query();
    test_wait_basic();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_events.md
Name: keypad_events

Overview:
- Sits directly downstream of the CHIP-8 matrix keypad scanner and consumes its raw 16-bit key-state vector (bit n = hex key n, 1 = pressed).
- Debounces each key and generates one-cycle press/release pulses.
- Answers the CPU's key-query (EX9E/EXA1) combinationally.
- Implements the FX0A "wait for key" handshake: a key is reported only after a full press-then-release.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive clocks raw_keys[i] must differ from keys[i] before keys[i] flips. Legal range 1..255.
- CNT_W, 8: width of each per-key debounce counter. Must be at least clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- raw_keys  in  16  scanner key vector, synchronous to clk
- keys  out  16  debounced key state
- press_pulse  out  16  bit i high for one cycle when keys[i] rises
- release_pulse  out  16  bit i high for one cycle when keys[i] falls
- query_key  in  4  key index for EX9E/EXA1
- query_pressed  out  1  equals keys[query_key], combinational
- wait_start  in  1  one-cycle request to begin an FX0A wait
- wait_busy  out  1  high in WAIT_PRESS and WAIT_RELEASE
- wait_valid  out  1  high in DONE; wait_key is valid
- wait_key  out  4  captured key index
- wait_ack  in  1  CPU consumed wait_key

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, the following are 0: keys, press_pulse, release_pulse, wait_busy, wait_valid, wait_key, and all debounce counters. The FSM is in IDLE. Asserting reset mid-wait aborts the wait with no valid report.

Debounce, per key i (all registered):
- If raw_keys[i]==keys[i]: cnt[i]<=0.
- Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: keys[i]<=raw_keys[i] and cnt[i]<=0.
- Otherwise: cnt[i]<=cnt[i]+1.
- Latency: keys[i] flips at the DEBOUNCE_CYCLES-th consecutive rising edge that samples a mismatch.
- A single matching sample resets the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- With DEBOUNCE_CYCLES=1 the block reduces to a one-cycle register.

Pulses:
- press_pulse[i] and release_pulse[i] are registered. They go high in the same cycle keys[i] takes its new value and stay high for exactly one cycle.
- press_pulse[i] and release_pulse[i] are never both high.
- Several keys may pulse in the same cycle.

query_pressed:
- Pure mux of the registered keys; no added latency.

Wait FSM (IDLE, WAIT_PRESS, WAIT_RELEASE, DONE):
- IDLE: wait_start -> WAIT_PRESS. Keys already held at start do not count; only new press_pulse events are considered.
- WAIT_PRESS: if press_pulse!=0, wait_key<=index of the lowest set bit, then go to WAIT_RELEASE. Otherwise stay.
- WAIT_RELEASE: if release_pulse[wait_key]==1, go to DONE. Presses and releases of other keys are ignored, and wait_key does not change.
- DONE: wait_valid=1 and wait_key is held stable. On wait_ack, go to IDLE. If wait_ack and wait_start occur in the same cycle, go directly to WAIT_PRESS.
- wait_start outside IDLE (and outside the DONE+wait_ack case) is ignored.
- wait_ack outside DONE is ignored.
- wait_busy and wait_valid are decoded from the state register and are never both high.
- Latency: DONE is entered at the edge after the cycle in which release_pulse[wait_key] is high.

Test Plan:
- Reset and debounce: DEBOUNCE_CYCLES=8; hold rst_n=0, then release it; set raw_keys=16'h0020 -> keys stays 0 for 7 edges, becomes 16'h0020 on the 8th edge; press_pulse=16'h0020 for exactly one cycle.
- Glitch rejection: raw_keys bit 3 high for 7 cycles, low for 1, high for 7 -> keys[3] never rises and press_pulse stays 0.
- Query: keys=16'h8001 after debounce; query_key=4'hF -> query_pressed=1; query_key=4'h1 -> query_pressed=0, in the same cycle as the query_key change.
- FX0A basic: key 0xA held before wait_start -> ignored. Then press key 0x5 and key 0xC in the same debounce window -> wait_key=5. Release 0xC -> still busy. Release 0x5 -> wait_valid=1 with wait_key=5 until wait_ack; the FSM returns to IDLE the cycle after ack.
- Back-to-back: in DONE, assert wait_ack and wait_start in the same cycle -> wait_busy=1 the next cycle and wait_valid=0. Then press and release key 0x0 -> wait_key=0.
- Reset mid-operation: in WAIT_RELEASE with wait_key=7, pulse rst_n low for one cycle -> all outputs 0 immediately (asynchronous), state IDLE. A later release of key 7 produces no wait_valid.
